// File: rtl/if_pkg.sv
// Shared constants and the RUN/LOAD state encoding for the instruction fetch unit.
package if_pkg;

  localparam int unsigned IF_ADDR_W  = 32;
  localparam int unsigned IF_INSTR_W = 32;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_LOAD = 1'b1
  } if_mode_e;

endpackage

// File: rtl/if_rsp_fifo.sv
// Response buffer: circular FIFO with sync reset and sync clear; the head is
// shown combinationally and reads as zero while empty.
module if_rsp_fifo
  import if_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != (PW+1)'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  assign valid   = (cnt != '0);
  assign count   = cnt;
  assign dout    = valid ? store[rd_ptr] : '0;

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; not reset since emptiness gates the visible head.
  always_ff @(posedge clk) begin
    if (do_push && !(rst || clr)) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: byte-loadable memory, RUN/LOAD mode FSM and a
// one-cycle fetch pipeline feeding a response FIFO.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W      = IF_ADDR_W,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned INSTR_W     = IF_INSTR_W,
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [7:0]         ld_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_pc,
  input  logic               flush,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_pc,
  output logic               rsp_misalign,
  output logic               rsp_oob,
  output logic               mode
);

  localparam int unsigned NB  = INSTR_W / 8;
  localparam int unsigned MW  = $clog2(DEPTH_BYTES);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PLW = INSTR_W + ADDR_W + 2;

  if_mode_e          state_q;
  if_mode_e          state_d;
  logic [7:0]        mem [DEPTH_BYTES];
  logic              inflight_q;
  logic [ADDR_W-1:0] pc_q;
  logic              req_fire;
  logic [CW-1:0]     count;
  logic [INSTR_W-1:0] raw_instr;
  logic              misalign;
  logic              oob;
  logic [PLW-1:0]    push_data;
  logic [PLW-1:0]    head;
  logic              ld_in_range;

  // Mode register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MODE_RUN;
    else     state_q <= state_d;
  end

  // Mode transitions: enter LOAD on any load byte, leave on the first idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_RUN:  if (ld_en)  state_d = MODE_LOAD;
      MODE_LOAD: if (!ld_en) state_d = MODE_RUN;
      default:   state_d = MODE_RUN;
    endcase
  end

  assign mode = (state_q == MODE_LOAD);

  // Memory load port; out-of-range addresses are dropped, reset leaves contents.
  assign ld_in_range = ({1'b0, ld_addr} < (ADDR_W+1)'(DEPTH_BYTES));

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range) mem[ld_addr[MW-1:0]] <= ld_data;
  end

  assign req_ready = !rst && !ld_en && !flush &&
                     (((CW+1)'(count) + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH));
  assign req_fire  = req_valid && req_ready;

  // Capture accepted pc; the response is formed and pushed the following cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= req_fire;
      if (req_fire) pc_q <= req_pc;
    end
  end

  // Byte gather for the inflight pc; indices are truncated so a read never
  // leaves the array, and any flagged access is zeroed afterwards.
  always_comb begin
    raw_instr = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (BIG_ENDIAN) raw_instr[INSTR_W-1-8*i -: 8] = mem[MW'(pc_q + ADDR_W'(i))];
      else            raw_instr[8*i +: 8]           = mem[MW'(pc_q + ADDR_W'(i))];
    end
  end

  assign misalign  = ((pc_q % ADDR_W'(NB)) != '0);
  assign oob       = (({1'b0, pc_q} + (ADDR_W+1)'(NB - 1)) >= (ADDR_W+1)'(DEPTH_BYTES));
  assign push_data = {oob, misalign, pc_q, (misalign || oob) ? '0 : raw_instr};

  if_rsp_fifo #(
    .WIDTH (PLW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (inflight_q && !flush),
    .din   (push_data),
    .pop   (rsp_valid && rsp_ready),
    .dout  (head),
    .valid (rsp_valid),
    .count (count)
  );

  assign {rsp_oob, rsp_misalign, rsp_pc, rsp_instr} = head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (little- and big-endian instances).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;
  logic        req_valid;
  logic        req_ready, req_ready_be;
  logic [31:0] req_pc;
  logic        flush;
  logic        rsp_ready;
  logic        rsp_valid, rsp_valid_be;
  logic [31:0] rsp_instr, rsp_instr_be;
  logic [31:0] rsp_pc, rsp_pc_be;
  logic        rsp_misalign, rsp_misalign_be;
  logic        rsp_oob, rsp_oob_be;
  logic        mode, mode_be;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(32), .DEPTH_BYTES(1024), .INSTR_W(32), .BIG_ENDIAN(1'b0), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc),
    .rsp_misalign(rsp_misalign), .rsp_oob(rsp_oob), .mode(mode)
  );

  instr_fetch_unit #(
    .ADDR_W(32), .DEPTH_BYTES(1024), .INSTR_W(32), .BIG_ENDIAN(1'b1), .FIFO_DEPTH(2)
  ) dut_be (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready_be), .req_pc(req_pc), .flush(flush),
    .rsp_valid(rsp_valid_be), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr_be), .rsp_pc(rsp_pc_be),
    .rsp_misalign(rsp_misalign_be), .rsp_oob(rsp_oob_be), .mode(mode_be)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
  endtask

  // Issue one request, wait the fixed two edges to the push, and report the head.
  task automatic fetch(input logic [31:0] pc, output logic v, output logic [31:0] ins,
                       output logic [31:0] rpc, output logic mis, output logic oo);
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = pc;
    tick();
    req_valid = 1'b0;
    tick();
    v = rsp_valid; ins = rsp_instr; rpc = rsp_pc; mis = rsp_misalign; oo = rsp_oob;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; req_valid = 1'b0;
    req_pc = '0; flush = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode); end
    n_checks++; if ({rsp_instr, rsp_pc, rsp_misalign, rsp_oob} !== 66'h0) begin n_fail++;
      $display("FAIL reset_rsp_zero: got instr=%h pc=%h mis=%b oob=%b want all 0", rsp_instr, rsp_pc, rsp_misalign, rsp_oob); end
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_load();
    load_byte(32'd0, 8'h3D);
    n_checks++; if (mode !== 1'b1) begin n_fail++; $display("FAIL load_mode: got %b want 1", mode); end
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_req_ready: got %b want 0", req_ready); end
    load_byte(32'd1, 8'h00); load_byte(32'd2, 8'h10); load_byte(32'd3, 8'h21);
    load_byte(32'd4, 8'h11); load_byte(32'd5, 8'h22); load_byte(32'd6, 8'h33); load_byte(32'd7, 8'h44);
    load_byte(32'd8, 8'h01); load_byte(32'd9, 8'h02); load_byte(32'd10, 8'h03); load_byte(32'd11, 8'h04);
    load_byte(32'd1020, 8'hAA); load_byte(32'd1021, 8'hBB); load_byte(32'd1022, 8'hCC); load_byte(32'd1023, 8'hDD);
    load_byte(32'd1024, 8'h55);  // out of range, must not alias onto byte 0
    ld_en = 1'b0;
    tick();
    n_checks++; if (mode !== 1'b0) begin n_fail++; $display("FAIL load_exit_mode: got %b want 0", mode); end
  endtask

  task automatic test_fetch_endian();
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_latency_early: got valid=%b want 0", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_instr !== 32'h2110003D) begin n_fail++; $display("FAIL fetch_le_instr: got %h want 2110003d", rsp_instr); end
    n_checks++; if (rsp_instr_be !== 32'h3D001021) begin n_fail++; $display("FAIL fetch_be_instr: got %h want 3d001021", rsp_instr_be); end
    n_checks++; if ({rsp_pc, rsp_misalign, rsp_oob} !== 34'h0) begin n_fail++;
      $display("FAIL fetch_pc_flags: got pc=%h mis=%b oob=%b want 0/0/0", rsp_pc, rsp_misalign, rsp_oob); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pop: got valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_flags();
    logic [31:0] pcs  [6] = '{32'd2, 32'd1022, 32'd1024, 32'd1020, 32'hFFFF_FFFE, 32'd0};
    logic [31:0] exi  [6] = '{32'h0, 32'h0, 32'h0, 32'hDDCCBBAA, 32'h0, 32'h2110003D};
    logic        exm  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exo  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic v, mis, oo;
    logic [31:0] ins, rpc;
    for (int i = 0; i < 6; i++) begin
      fetch(pcs[i], v, ins, rpc, mis, oo);
      n_checks++;
      if ({v, ins, rpc, mis, oo} !== {1'b1, exi[i], pcs[i], exm[i], exo[i]}) begin
        n_fail++;
        $display("FAIL flags_pc_%h: got v=%b instr=%h pc=%h mis=%b oob=%b want v=1 instr=%h pc=%h mis=%b oob=%b",
                 pcs[i], v, ins, rpc, mis, oo, exi[i], pcs[i], exm[i], exo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] head_instr;
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b want 1", req_ready); end
    tick();
    req_pc = 32'd4;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", req_ready); end
    tick();
    req_pc = 32'd8;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2: got %b want 0", req_ready); end
    tick();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", req_ready); end
    head_instr = rsp_instr;
    n_checks++; if ({rsp_valid, rsp_pc} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h want 1/0", rsp_valid, rsp_pc); end
    req_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_pc, rsp_instr} !== {1'b1, 32'd0, head_instr}) begin n_fail++;
      $display("FAIL bp_stable: got v=%b pc=%h instr=%h want 1/0/%h", rsp_valid, rsp_pc, rsp_instr, head_instr); end
    rsp_ready = 1'b1;
    tick();
    n_checks++; if ({rsp_valid, rsp_pc, rsp_instr} !== {1'b1, 32'd4, 32'h44332211}) begin n_fail++;
      $display("FAIL bp_second: got v=%b pc=%h instr=%h want 1/4/44332211", rsp_valid, rsp_pc, rsp_instr); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    req_pc = 32'd4;
    tick();
    req_pc = 32'd8;
    #1;
    n_checks++; if ({req_ready, rsp_valid, rsp_pc} !== {1'b0, 1'b1, 32'd0}) begin n_fail++;
      $display("FAIL b2b_first: got ready=%b v=%b pc=%h want 0/1/0", req_ready, rsp_valid, rsp_pc); end
    tick();
    #1;
    n_checks++; if ({req_ready, rsp_valid, rsp_pc} !== {1'b1, 1'b1, 32'd4}) begin n_fail++;
      $display("FAIL b2b_pushpop: got ready=%b v=%b pc=%h want 1/1/4", req_ready, rsp_valid, rsp_pc); end
    req_valid = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_flush();
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    req_pc = 32'd4;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    tick();
    flush = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cleared: got %b want 0", rsp_valid); end
    req_valid = 1'b1; req_pc = 32'd8;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_pc, rsp_instr} !== {1'b1, 32'd8, 32'h04030201}) begin n_fail++;
      $display("FAIL flush_new: got v=%b pc=%h instr=%h want 1/8/04030201", rsp_valid, rsp_pc, rsp_instr); end
    rsp_ready = 1'b1;
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_only_one: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic v, mis, oo;
    logic [31:0] ins, rpc;
    rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'd0;
    tick();
    req_pc = 32'd4;
    tick();
    req_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", req_ready); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_pc} !== {1'b0, 32'd0}) begin n_fail++;
      $display("FAIL rstmid_dropped: got v=%b pc=%h want 0/0", rsp_valid, rsp_pc); end
    fetch(32'd0, v, ins, rpc, mis, oo);
    n_checks++; if ({v, ins} !== {1'b1, 32'h2110003D}) begin n_fail++;
      $display("FAIL rstmid_mem_kept: got v=%b instr=%h want 1/2110003d", v, ins); end
  endtask

  task automatic test_load_concurrent();
    rsp_ready = 1'b0; ld_en = 1'b1; ld_addr = 32'd4; ld_data = 8'h99;
    req_valid = 1'b1; req_pc = 32'd4;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ldc_ready: got %b want 0", req_ready); end
    tick();
    ld_en = 1'b0;
    n_checks++; if (mode !== 1'b1) begin n_fail++; $display("FAIL ldc_mode: got %b want 1", mode); end
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ldc_ready_after: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_pc, rsp_instr} !== {1'b1, 32'd4, 32'h44332299}) begin n_fail++;
      $display("FAIL ldc_visible: got v=%b pc=%h instr=%h want 1/4/44332299", rsp_valid, rsp_pc, rsp_instr); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch_endian();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_load_concurrent();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
